// File: rtl/and_reduce_sequencer_pkg.sv
// Shared state encodings and sizing helpers for the AND-reduce sequencer.
`ifndef AND_REDUCE_SEQUENCER_STATES_SVH
`define AND_REDUCE_SEQUENCER_STATES_SVH
`define ARS_ST_IDLE 2'd0
`define ARS_ST_RUN  2'd1
`define ARS_ST_DONE 2'd2
`endif

package and_reduce_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = `ARS_ST_IDLE,
        ST_RUN  = `ARS_ST_RUN,
        ST_DONE = `ARS_ST_DONE
    } state_e;

    // Lane counter width; never zero so a single-lane build still has a counter bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/and_reduce_sequencer_serial_and.sv
// Single shared WAY-input AND tree, reused for every lane by the sequencer.
module serial_and
    import and_reduce_sequencer_pkg::*;
#(
    parameter int unsigned WAY = 2
) (
    input  logic [WAY-1:0] a_i,
    output logic           y_c
);

    assign y_c = &a_i;

endmodule

// File: rtl/and_reduce_sequencer.sv
// Time-multiplexed lane AND reducer: one bundle in, one lane per cycle, WIRE-bit result out.
module and_reduce_sequencer
    import and_reduce_sequencer_pkg::*;
#(
    parameter int unsigned WAY  = 2,
    parameter int unsigned WIRE = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WAY*WIRE-1:0]  in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIRE-1:0]      out,
    output logic                 busy
);

    localparam int unsigned SIZE = WAY * WIRE;
    localparam int unsigned CW   = cnt_width(WIRE);

    state_e            state_q, state_d;
    logic [CW-1:0]     idx_q, idx_d;
    logic [SIZE-1:0]   bundle_q, bundle_d;
    logic [WIRE-1:0]   out_q, out_d;
    logic [WAY-1:0]    lane_c;
    logic              lane_and_c;

    // Lane mux feeding the shared AND tree.
    always_comb begin
        lane_c = '0;
        for (int k = 0; k < int'(WIRE); k++) begin
            if (idx_q == CW'(k)) begin
                lane_c = bundle_q[k*WAY +: WAY];
            end
        end
    end

    serial_and #(.WAY(WAY)) u_serial_and (
        .a_i (lane_c),
        .y_c (lane_and_c)
    );

    // Next-state, counter, bundle capture and per-lane result write.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bundle_d = bundle_q;
        out_d    = out_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    bundle_d = in;
                    out_d    = '0;
                    idx_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int k = 0; k < int'(WIRE); k++) begin
                    if (idx_q == CW'(k)) begin
                        out_d[k] = lane_and_c;
                    end
                end
                if (idx_q == CW'(WIRE - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            bundle_q <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bundle_q <= bundle_d;
            out_q    <= out_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out       = out_q;

endmodule

// File: tb/tb_and_reduce_sequencer.sv
// Directed scoreboard bench: main build WAY=2/WIRE=4 plus WAY=3/WIRE=1 and WAY=1/WIRE=4 corners.
module tb_and_reduce_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Main build, WAY=2 WIRE=4
    logic       m_in_valid, m_in_ready, m_out_valid, m_out_ready, m_busy;
    logic [7:0] m_in;
    logic [3:0] m_out;

    // Corner build, WAY=3 WIRE=1
    logic       c1_in_valid, c1_in_ready, c1_out_valid, c1_out_ready, c1_busy;
    logic [2:0] c1_in;
    logic [0:0] c1_out;

    // Corner build, WAY=1 WIRE=4
    logic       c2_in_valid, c2_in_ready, c2_out_valid, c2_out_ready, c2_busy;
    logic [3:0] c2_in;
    logic [3:0] c2_out;

    and_reduce_sequencer #(.WAY(2), .WIRE(4)) u_main (
        .clk(clk), .reset(reset), .in_valid(m_in_valid), .in_ready(m_in_ready), .in(m_in),
        .out_valid(m_out_valid), .out_ready(m_out_ready), .out(m_out), .busy(m_busy)
    );

    and_reduce_sequencer #(.WAY(3), .WIRE(1)) u_c1 (
        .clk(clk), .reset(reset), .in_valid(c1_in_valid), .in_ready(c1_in_ready), .in(c1_in),
        .out_valid(c1_out_valid), .out_ready(c1_out_ready), .out(c1_out), .busy(c1_busy)
    );

    and_reduce_sequencer #(.WAY(1), .WIRE(4)) u_c2 (
        .clk(clk), .reset(reset), .in_valid(c2_in_valid), .in_ready(c2_in_ready), .in(c2_in),
        .out_valid(c2_out_valid), .out_ready(c2_out_ready), .out(c2_out), .busy(c2_busy)
    );

    logic [3:0] exp_q[$];
    logic [3:0] cur_exp;
    int         cycles;

    function automatic logic [3:0] ref_and2x4(input logic [7:0] b);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = b[2*k] & b[2*k+1];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_accept(input logic [7:0] b);
        @(negedge clk);
        check("accept_in_ready", 32'(m_in_ready), 32'd1);
        m_in_valid = 1'b1;
        m_in       = b;
        @(negedge clk);
        m_in_valid = 1'b0;
        exp_q.push_back(ref_and2x4(b));
        check("run_busy", 32'(m_busy), 32'd1);
        check("run_in_ready", 32'(m_in_ready), 32'd0);
    endtask

    // Waits for out_valid (bounded); optionally scribbles on the input while running.
    task automatic m_wait_done(input bit toggle);
        cycles = 0;
        while (!m_out_valid && cycles < 20) begin
            if (toggle) begin
                m_in       = 8'($urandom);
                m_in_valid = 1'b1;
            end
            @(negedge clk);
            cycles++;
        end
        m_in_valid = 1'b0;
        check("latency", 32'(cycles), 32'd4);
    endtask

    task automatic m_pop_check(input int hold);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        cur_exp = exp_q.pop_front();
        check("result", 32'(m_out), 32'(cur_exp));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(m_out_valid), 32'd1);
            check("hold_out", 32'(m_out), 32'(cur_exp));
            check("hold_in_ready", 32'(m_in_ready), 32'd0);
        end
        m_out_ready = 1'b1;
        @(negedge clk);
        m_out_ready = 1'b0;
        check("post_hs_valid", 32'(m_out_valid), 32'd0);
        check("post_hs_in_ready", 32'(m_in_ready), 32'd1);
        check("post_hs_out_held", 32'(m_out), 32'(cur_exp));
    endtask

    initial begin
        reset = 1'b1;
        m_in_valid = 1'b0; m_in = '0; m_out_ready = 1'b0;
        c1_in_valid = 1'b0; c1_in = '0; c1_out_ready = 1'b0;
        c2_in_valid = 1'b0; c2_in = '0; c2_out_ready = 1'b0;

        // Reset then idle
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", 32'(m_in_ready), 32'd1);
        check("rst_out_valid", 32'(m_out_valid), 32'd0);
        check("rst_out", 32'(m_out), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);

        // Basic bundle with backpressure
        m_accept(8'b11_01_11_00);
        m_wait_done(1'b0);
        check("basic_const", 32'(m_out), 32'h0000000a);
        m_pop_check(5);

        // Second bundle all ones
        m_accept(8'hFF);
        m_wait_done(1'b0);
        check("ones_const", 32'(m_out), 32'hf);
        m_pop_check(0);

        // Input activity during RUN must not disturb the captured bundle
        m_accept(8'hA5);
        m_wait_done(1'b1);
        m_pop_check(1);
        m_accept(8'b11_10_11_01);
        m_wait_done(1'b1);
        m_pop_check(0);

        // Reset while RUN is at lane 2
        m_accept(8'hFF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        check("midrst_in_ready", 32'(m_in_ready), 32'd1);
        check("midrst_out_valid", 32'(m_out_valid), 32'd0);
        check("midrst_out", 32'(m_out), 32'd0);
        check("midrst_busy", 32'(m_busy), 32'd0);
        m_accept(8'h00);
        m_wait_done(1'b0);
        check("zeros_const", 32'(m_out), 32'd0);
        m_pop_check(0);

        // WAY=3 WIRE=1: 3'b111 then 3'b110
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            c1_in_valid = 1'b1;
            c1_in       = (t == 0) ? 3'b111 : 3'b110;
            @(negedge clk);
            c1_in_valid = 1'b0;
            cycles = 0;
            while (!c1_out_valid && cycles < 20) begin
                @(negedge clk);
                cycles++;
            end
            check("c1_latency", 32'(cycles), 32'd1);
            check("c1_out", 32'(c1_out), (t == 0) ? 32'd1 : 32'd0);
            c1_out_ready = 1'b1;
            @(negedge clk);
            c1_out_ready = 1'b0;
            check("c1_idle", 32'(c1_in_ready), 32'd1);
        end

        // WAY=1 WIRE=4: result equals input
        @(negedge clk);
        c2_in_valid = 1'b1;
        c2_in       = 4'b1001;
        @(negedge clk);
        c2_in_valid = 1'b0;
        cycles = 0;
        while (!c2_out_valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check("c2_latency", 32'(cycles), 32'd4);
        check("c2_out", 32'(c2_out), 32'h9);
        c2_out_ready = 1'b1;
        @(negedge clk);
        c2_out_ready = 1'b0;
        check("c2_idle", 32'(c2_in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
